rx_flag_scheduler: RTL

RX_FLAG_SCHEDULER -- requirements
Module: rx_flag_scheduler

---
 rtl/rx_flag_sched_pkg.sv | 13 +
 rtl/rx_flag_sched_timeout.sv | 28 ++
 rtl/rx_flag_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rx_flag_sched_pkg.sv
// Shared types and default configuration for the receive-flag scheduler.
package rx_flag_sched_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH_RF  = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2
    } state_t;

endpackage

// File: rtl/rx_flag_sched_timeout.sv
// Offer-age counter: raises expired_c on the last cycle an unanswered offer may be held.
module rx_flag_sched_timeout
    import rx_flag_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    assign expired_c = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside an offer, so every new offer starts from a fresh count.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (!expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rx_flag_scheduler.sv
// Round-robin scheduler over a per-channel arrival flags file: flushes after reset, then offers set flags.
// Optional offer abandon after TIMEOUT_CYCLES is enabled by defining RX_FLAG_SCHED_TIMEOUT_EN.
module rx_flag_scheduler
    import rx_flag_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_RF  = DEFAULT_ADDR_WIDTH_RF,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [ADDR_WIDTH_RF-1:0] rx_channel,
    input  logic                     flag_read_data,
    output logic                     rx_write_enable,
    output logic [ADDR_WIDTH_RF-1:0] flag_wr_addr,
    output logic                     rtr_write_enable,
    output logic [ADDR_WIDTH_RF-1:0] flag_rd_addr,
    output logic                     grant_valid,
    output logic [ADDR_WIDTH_RF-1:0] grant_channel,
    input  logic                     grant_ready,
    output logic                     init_done
);

    localparam int unsigned N = 1 << ADDR_WIDTH_RF;

    state_t                   state, state_nxt;
    logic [ADDR_WIDTH_RF-1:0] ptr, ptr_nxt;
    logic [ADDR_WIDTH_RF-1:0] grant_channel_nxt;
    logic                     init_done_nxt;
    logic [ADDR_WIDTH_RF-1:0] rd_addr;
    logic                     clear_req;
    logic                     offer_active;
    logic                     collision;
    logic                     timeout_expired;

    // Arrivals go straight through to the set port of the flags file.
    assign rx_write_enable = rx_valid;
    assign flag_wr_addr    = rx_channel;

`ifdef RX_FLAG_SCHED_TIMEOUT_EN
    rx_flag_sched_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .run       (state == OFFER),
        .expired_c (timeout_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_expired    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FLUSH;
            ptr           <= '0;
            grant_channel <= '0;
            init_done     <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            grant_channel <= grant_channel_nxt;
            init_done     <= init_done_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        ptr_nxt           = ptr;
        grant_channel_nxt = grant_channel;
        init_done_nxt     = init_done;
        rd_addr           = ptr;
        clear_req         = 1'b0;
        offer_active      = 1'b0;

        case (state)
            FLUSH: begin
                clear_req = 1'b1;
                ptr_nxt   = ptr + ADDR_WIDTH_RF'(1);
                if (ptr == ADDR_WIDTH_RF'(N - 1)) begin
                    state_nxt     = SCAN;
                    ptr_nxt       = '0;
                    init_done_nxt = 1'b1;
                end
            end
            SCAN: begin
                if (flag_read_data) begin
                    state_nxt         = OFFER;
                    grant_channel_nxt = ptr;
                end else begin
                    ptr_nxt = ptr + ADDR_WIDTH_RF'(1);
                end
            end
            OFFER: begin
                rd_addr      = grant_channel;
                offer_active = 1'b1;
                if (grant_ready) begin
                    clear_req = 1'b1;
                    state_nxt = SCAN;
                    ptr_nxt   = grant_channel + ADDR_WIDTH_RF'(1);
                end else if (timeout_expired) begin
                    state_nxt = SCAN;
                    ptr_nxt   = grant_channel + ADDR_WIDTH_RF'(1);
                end
            end
            default: begin
                state_nxt = FLUSH;
                ptr_nxt   = '0;
            end
        endcase
    end

    // A same-cycle arrival on the address being cleared wins, so the new message stays flagged.
    assign collision        = rx_valid && (rx_channel == rd_addr);
    assign flag_rd_addr     = rd_addr;
    assign rtr_write_enable = clear_req && !collision && !reset;
    assign grant_valid      = offer_active && !reset;

endmodule
